// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - button-driven load/run/pause sequencer with prescaled counter
//
// Purpose:
//   Three push buttons (set, load, start) drive a small FSM.
//   - set captures the terminal value.
//   - load captures the start count and the mode.
//   - start runs the counter, and a second start pauses or resumes it.
//   In RUN the count advances once every TICK_DIV clocks. When the count
//   equals the terminal value, the FSM moves to DONE.
//
// Build option:
//   CONTROL_SEQUENCER_DEBOUNCE_EN - when defined, each synchronized button
//   bit must hold a new level for DEB_CYCLES consecutive clocks before that
//   level is accepted. When undefined, the synchronized level is used as is.
//
// Parameters:
//   TICK_DIV       clkIn cycles per count tick (2 .. 2^26)
//   DEB_CYCLES     debounce stability window in cycles (1 .. 2^20)
//
// Ports:
//   clkIn          in   1  clock, rising edge
//   resetIn        in   1  asynchronous active-high reset
//   setLoadStartIn in   3  raw buttons: [2]=set, [1]=load, [0]=start
//   modeSelIn      in   4  mode value, sampled on load
//   dataIn         in   8  value captured on set (limit) or load (count)
//   stateOut       out  3  IDLE=0 SET=1 LOAD=2 RUN=3 PAUSE=4 DONE=5
//   countOut       out  8  running count
//   limitOut       out  8  terminal value
//   modeOut        out  4  latched mode
//   runningOut     out  1  state is RUN
//   doneOut        out  1  state is DONE
//   tickOut        out  1  one-cycle pulse on each count tick in RUN

module control_sequencer #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clkIn,
  input  logic       resetIn,
  input  logic [2:0] setLoadStartIn,
  input  logic [3:0] modeSelIn,
  input  logic [7:0] dataIn,
  output logic [2:0] stateOut,
  output logic [7:0] countOut,
  output logic [7:0] limitOut,
  output logic [3:0] modeOut,
  output logic       runningOut,
  output logic       doneOut,
  output logic       tickOut
);

  // The prescaler counts 0 .. TICK_DIV-1. One tick is issued on the cycle
  // that sees the last value.
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || TICK_DIV > 67108864) begin : gTickDivRange
    $error("control_sequencer: TICK_DIV out of range 2..2^26");
  end
  if (DEB_CYCLES < 1 || DEB_CYCLES > 1048576) begin : gDebCyclesRange
    $error("control_sequencer: DEB_CYCLES out of range 1..2^20");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } stateT;

  stateT         state;
  stateT         stateNext;
  logic [PW-1:0] preCnt;
  logic [PW-1:0] preNext;
  logic [7:0]    countNext;
  logic [7:0]    limitNext;
  logic [3:0]    modeNext;
  logic          tickNow;

  // ---------------------------------------------------------------------
  // Button conditioning: 2-flop synchronizer, optional debounce, edge detect
  // ---------------------------------------------------------------------
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] level;
  logic [2:0] prevLevel;
  logic [2:0] armed;
  logic [1:0] flushCnt;
  logic [2:0] pulse;

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= setLoadStartIn;
      sync2 <= sync1;
    end
  end

`ifdef CONTROL_SEQUENCER_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] debCnt [3];
  logic [2:0]    debLevel;

  // The counter tracks how long sync2 has disagreed with the accepted level.
  // Any sample that agrees with the accepted level restarts the window.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      debLevel <= '0;
      for (int i = 0; i < 3; i++) begin
        debCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == debLevel[i]) begin
          debCnt[i] <= '0;
        end else if (debCnt[i] == DEB_LAST) begin
          debLevel[i] <= sync2[i];
          debCnt[i]   <= '0;
        end else begin
          debCnt[i] <= debCnt[i] + DW'(1);
        end
      end
    end
  end

  assign level = debLevel;
`else
  assign level = sync2;
`endif

  // A bit is armed only after it has been seen released (sync2 low) once
  // the synchronizer holds post-reset samples. As a result, a button held
  // through reset release never produces a pulse, even though every
  // conditioning flop restarts at 0.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      prevLevel <= '0;
      armed     <= '0;
      flushCnt  <= '0;
    end else begin
      prevLevel <= level;
      if (flushCnt != 2'd2) begin
        flushCnt <= flushCnt + 2'd1;
      end else begin
        armed <= armed | ~sync2;
      end
    end
  end

  assign pulse = level & ~prevLevel & armed;

  // When pulses coincide, set wins over load, and load wins over start.
  logic setP;
  logic loadP;
  logic startP;

  assign setP   = pulse[2];
  assign loadP  = pulse[1] & ~pulse[2];
  assign startP = pulse[0] & ~pulse[1] & ~pulse[2];

  // ---------------------------------------------------------------------
  // FSM: state and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      state    <= IDLE;
      preCnt   <= '0;
      countOut <= '0;
      limitOut <= '0;
      modeOut  <= '0;
    end else begin
      state    <= stateNext;
      preCnt   <= preNext;
      countOut <= countNext;
      limitOut <= limitNext;
      modeOut  <= modeNext;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state, datapath next values, tick
  // ---------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    preNext   = preCnt;
    countNext = countOut;
    limitNext = limitOut;
    modeNext  = modeOut;
    tickNow   = 1'b0;

    case (state)
      IDLE: begin
        if (setP) begin
          limitNext = dataIn;
          stateNext = SET;
        end
      end

      SET: begin
        if (setP) begin
          limitNext = dataIn;
        end else if (loadP) begin
          countNext = dataIn;
          modeNext  = modeSelIn;
          stateNext = LOAD;
        end
      end

      LOAD: begin
        if (setP) begin
          stateNext = IDLE;
        end else if (loadP) begin
          countNext = dataIn;
          modeNext  = modeSelIn;
        end else if (startP) begin
          preNext   = '0;
          stateNext = RUN;
        end
      end

      RUN: begin
        // The terminal check comes before any tick. A count already equal
        // to the limit on RUN entry therefore finishes without incrementing.
        if (setP) begin
          stateNext = IDLE;
        end else if (countOut == limitOut) begin
          stateNext = DONE;
        end else if (startP) begin
          stateNext = PAUSE;
        end else if (preCnt == TICK_LAST) begin
          tickNow   = 1'b1;
          preNext   = '0;
          countNext = countOut + 8'd1;
        end else begin
          preNext = preCnt + PW'(1);
        end
      end

      PAUSE: begin
        // The prescaler holds its value, so the resumed run keeps its phase.
        if (setP) begin
          stateNext = IDLE;
        end else if (startP) begin
          stateNext = RUN;
        end
      end

      DONE: begin
        if (setP) begin
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign stateOut   = state;
  assign runningOut = (state == RUN);
  assign doneOut    = (state == DONE);
  assign tickOut    = tickNow;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
//
// Purpose:
//   Drives hand-timed button presses into control_sequencer with
//   TICK_DIV=4 and DEB_CYCLES=8. Every observed output is compared
//   against a hand-computed expected value.
//
// Build option:
//   CONTROL_SEQUENCER_DEBOUNCE_EN - when defined, the debounce-specific
//   sequence runs instead of the undebounced sequence.
//
// Ports: none (top-level bench).

module tb_control_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] btn;
  logic [3:0] modeSel;
  logic [7:0] dataIn;
  logic [2:0] stateOut;
  logic [7:0] countOut;
  logic [7:0] limitOut;
  logic [3:0] modeOut;
  logic       runningOut;
  logic       doneOut;
  logic       tickOut;

  int compared;
  int mismatched;

  control_sequencer #(
    .TICK_DIV  (4),
    .DEB_CYCLES(8)
  ) dut (
    .clkIn         (clk),
    .resetIn       (rst),
    .setLoadStartIn(btn),
    .modeSelIn     (modeSel),
    .dataIn        (dataIn),
    .stateOut      (stateOut),
    .countOut      (countOut),
    .limitOut      (limitOut),
    .modeOut       (modeOut),
    .runningOut    (runningOut),
    .doneOut       (doneOut),
    .tickOut       (tickOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".state"}, stateOut, 0);
    check({tag, ".count"}, countOut, 0);
    check({tag, ".limit"}, limitOut, 0);
    check({tag, ".mode"}, modeOut, 0);
    check({tag, ".running"}, runningOut, 0);
    check({tag, ".done"}, doneOut, 0);
    check({tag, ".tick"}, tickOut, 0);
  endtask

  // Advance n rising edges, then sample 1 ns later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

`ifdef CONTROL_SEQUENCER_DEBOUNCE_EN
  // 2 synchronizer edges + 8-cycle stability window + 1 edge-detect edge.
  localparam int LAT = 11;
`else
  localparam int LAT    = 3;
  localparam int SETTLE = 5;

  // Hold the buttons until the FSM reacts, then release them.
  // The task returns 1 ns after the reacting edge.
  task automatic press(input logic [2:0] b);
    btn = b;
    repeat (LAT) @(posedge clk);
    #1;
    btn = 3'b000;
  endtask

  task automatic settle();
    step(SETTLE);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    btn        = 3'b000;
    modeSel    = 4'h0;
    dataIn     = 8'h00;

    // Async reset must clear every output before any clock edge.
    #2;
    checkAllZero("reset");
    step(2);
    rst = 1'b0;
    step(4);

`ifdef CONTROL_SEQUENCER_DEBOUNCE_EN
    // A 5-cycle glitch is shorter than the 8-cycle window: no transition.
    dataIn = 8'h21;
    btn    = 3'b100;
    step(5);
    btn = 3'b000;
    step(25);
    check("debGlitch.state", stateOut, 0);
    check("debGlitch.limit", limitOut, 0);

    // A 20-cycle press produces exactly one transition, on edge LAT.
    dataIn = 8'h33;
    btn    = 3'b100;
    step(LAT - 1);
    check("debEarly.state", stateOut, 0);
    step(1);
    check("debPress.state", stateOut, 1);
    check("debPress.limit", limitOut, 8'h33);
    dataIn = 8'h66;
    step(20 - LAT);
    btn = 3'b000;
    step(30);
    check("debHold.state", stateOut, 1);
    check("debHold.limit", limitOut, 8'h33);
`else
    // Basic run: limit 5, count 2, mode A.
    // Expect ticks at RUN+4, +8, +12 and DONE at RUN+13.
    dataIn = 8'd5;
    press(3'b100);
    check("r39set.state", stateOut, 1);
    check("r39set.limit", limitOut, 5);
    settle();
    dataIn  = 8'd2;
    modeSel = 4'hA;
    press(3'b010);
    check("r39load.state", stateOut, 2);
    check("r39load.count", countOut, 2);
    check("r39load.mode", modeOut, 4'hA);
    settle();

    // The FSM reacts on the 3rd edge that samples the raw button high.
    btn = 3'b001;
    step(2);
    check("r16edge2.state", stateOut, 2);
    step(1);
    btn = 3'b000;
    check("r39run.state", stateOut, 3);
    check("r39run.running", runningOut, 1);
    check("r39run.tick", tickOut, 0);
    for (int k = 1; k <= 3; k++) begin
      step(3);
      check("r39tickPulse", tickOut, 1);
      check("r39preTick.count", countOut, 1 + k);
      step(1);
      check("r39postTick.count", countOut, 2 + k);
      check("r39postTick.tick", tickOut, 0);
    end
    step(1);
    check("r39done.state", stateOut, 5);
    check("r39done.done", doneOut, 1);
    check("r39done.running", runningOut, 0);
    check("r39done.mode", modeOut, 4'hA);
    check("r39done.count", countOut, 5);
    check("r39done.tick", tickOut, 0);
    step(6);
    check("r39hold.count", countOut, 5);
    check("r39hold.state", stateOut, 5);

    // set from DONE returns to IDLE with all data held.
    press(3'b100);
    check("r27idle.state", stateOut, 0);
    check("r27idle.count", countOut, 5);
    check("r27idle.limit", limitOut, 5);
    check("r27idle.mode", modeOut, 4'hA);
    settle();

    // Wrap run: limit 3, count 250, with a pause after 4 ticks.
    dataIn = 8'd3;
    press(3'b100);
    check("r40set.limit", limitOut, 3);
    settle();
    dataIn  = 8'd250;
    modeSel = 4'h5;
    press(3'b010);
    check("r40load.count", countOut, 250);
    settle();
    press(3'b001);
    check("r40run.state", stateOut, 3);
    check("r40run.count", countOut, 250);
    for (int k = 1; k <= 4; k++) begin
      step(4);
      check("r40tick.count", countOut, (250 + k) % 256);
    end

    // Pause lands at RUN+19 with the prescaler frozen at 2.
    press(3'b001);
    check("r26pause.state", stateOut, 4);
    check("r26pause.running", runningOut, 0);
    check("r26pause.count", countOut, 254);
    step(10);
    check("r26paused.state", stateOut, 4);
    check("r26paused.count", countOut, 254);
    check("r26paused.tick", tickOut, 0);

    // Resume: prescaler continues from 2, so the tick comes one cycle later.
    press(3'b001);
    check("r26resume.state", stateOut, 3);
    check("r26resume.tick", tickOut, 0);
    step(1);
    check("r26resumeTick", tickOut, 1);
    check("r26resumePre.count", countOut, 254);
    step(1);
    check("r26resumePost.count", countOut, 255);
    for (int k = 1; k <= 4; k++) begin
      step(4);
      check("r40wrap.count", countOut, (255 + k) % 256);
    end
    check("r40preDone.state", stateOut, 3);
    step(1);
    check("r40done.state", stateOut, 5);
    check("r40done.count", countOut, 3);
    step(4);
    check("r40doneHold.count", countOut, 3);

    // count == limit on RUN entry: DONE after one cycle, no tick.
    press(3'b100);
    settle();
    dataIn = 8'd7;
    press(3'b100);
    check("r41set.limit", limitOut, 7);
    settle();
    press(3'b010);
    check("r41load.count", countOut, 7);
    settle();
    press(3'b001);
    check("r41run.state", stateOut, 3);
    check("r41run.tick", tickOut, 0);
    step(1);
    check("r41done.state", stateOut, 5);
    check("r41done.count", countOut, 7);

    // Simultaneous set+load+start in LOAD: set wins and the others are dropped.
    press(3'b100);
    settle();
    dataIn = 8'd9;
    press(3'b100);
    check("r42set.limit", limitOut, 9);
    settle();
    dataIn  = 8'd20;
    modeSel = 4'h3;
    press(3'b010);
    check("r42load.state", stateOut, 2);
    check("r42load.count", countOut, 20);
    settle();
    dataIn  = 8'd9;
    modeSel = 4'hC;
    press(3'b111);
    check("r42all.state", stateOut, 0);
    check("r42all.limit", limitOut, 9);
    check("r42all.count", countOut, 20);
    check("r42all.mode", modeOut, 4'h3);
    step(8);
    check("r42after.state", stateOut, 0);
    check("r42after.running", runningOut, 0);

    // Pulses not listed for IDLE are ignored.
    press(3'b001);
    check("r28start.state", stateOut, 0);
    settle();
    dataIn = 8'd77;
    press(3'b010);
    check("r28load.state", stateOut, 0);
    check("r28load.count", countOut, 20);
    settle();

    // A held button gives a single pulse; a later dataIn change is not captured.
    dataIn = 8'h44;
    btn    = 3'b100;
    step(LAT);
    check("r16hold.state", stateOut, 1);
    check("r16hold.limit", limitOut, 8'h44);
    dataIn = 8'h55;
    step(20);
    check("r16held.limit", limitOut, 8'h44);
    btn = 3'b000;
    settle();

    // Reset mid-RUN at count 4 while start is held.
    dataIn = 8'd2;
    press(3'b010);
    check("r43load.count", countOut, 2);
    settle();
    press(3'b001);
    step(8);
    check("r43mid.count", countOut, 4);
    check("r43mid.state", stateOut, 3);
    btn = 3'b001;
    #1;
    rst = 1'b1;
    #1;
    checkAllZero("r43async");
    step(2);
    rst = 1'b0;
    step(10);
    check("r43held.state", stateOut, 0);
    check("r43held.count", countOut, 0);
    check("r43held.running", runningOut, 0);
    btn = 3'b000;
    settle();

    // After the held button is released, presses work again.
    dataIn = 8'h12;
    press(3'b100);
    check("r43recover.state", stateOut, 1);
    check("r43recover.limit", limitOut, 8'h12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
